// File: rtl/parking_pkg.sv
// parking_pkg: shared defaults, occupancy type and count-update action for the parking sensor conditioner
package parking_pkg;
    localparam int DEFAULT_DEB_CYCLES = 4;
    localparam int DEFAULT_CAPACITY = 8;
    typedef logic [$clog2(DEFAULT_CAPACITY+1)-1:0] occ_t;
    typedef enum logic [1:0] {HOLD, INC, DEC} occ_act_e;
endpackage

// File: rtl/parking_debounce.sv
// parking_debounce: two-flop synchroniser, stable-count debounce and falling-edge pulse for one sensor
module parking_debounce import parking_pkg::*; #(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic fall_pulse
);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    logic [1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, prev_q, prev_d;
    logic differ, done;
    always_comb begin
        sync_d = {sync_q[0], raw_in};
        differ = sync_q[1] != level_q;
        done = cnt_q == CW'(DEB_CYCLES - 1);
        cnt_d = (!differ || done) ? '0 : cnt_q + CW'(1);
        level_d = (differ && done) ? ~level_q : level_q;
        prev_d = level_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q <= '0;
            level_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            level_q <= level_d;
            prev_q <= prev_d;
        end
    end
    assign level_out = level_q;
    assign fall_pulse = prev_q & ~level_q;
endmodule

// File: rtl/parking_sensor_conditioner.sv
// parking_sensor_conditioner: debounced sensors, car pulses and saturating occupancy; PARK_ERR_FLAG_EN adds a sticky count_err flag
module parking_sensor_conditioner import parking_pkg::*; #(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES,
    parameter int CAPACITY = DEFAULT_CAPACITY,
    localparam int CNT_W = $clog2(CAPACITY + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_entrance_raw,
    input  logic sensor_exit_raw,
    output logic sensor_entrance,
    output logic sensor_exit,
    output logic car_in_pulse,
    output logic car_out_pulse,
    output logic [CNT_W-1:0] occupancy,
    output logic lot_full,
    output logic lot_empty
`ifdef PARK_ERR_FLAG_EN
    ,
    input  logic err_clr,
    output logic count_err
`endif
);
    logic [CNT_W-1:0] occ_q, occ_d;
    occ_act_e act;
    logic in_only, out_only;
    parking_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ent (
        .clk(clk), .rst(rst), .raw_in(sensor_entrance_raw),
        .level_out(sensor_entrance), .fall_pulse(car_in_pulse)
    );
    parking_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ext (
        .clk(clk), .rst(rst), .raw_in(sensor_exit_raw),
        .level_out(sensor_exit), .fall_pulse(car_out_pulse)
    );
    assign lot_full = occ_q == CNT_W'(CAPACITY);
    assign lot_empty = occ_q == '0;
    assign occupancy = occ_q;
    // simultaneous in and out cancel, so only lone pulses move the count
    always_comb begin
        in_only = car_in_pulse & ~car_out_pulse;
        out_only = car_out_pulse & ~car_in_pulse;
        act = (in_only && !lot_full) ? INC : (out_only && !lot_empty) ? DEC : HOLD;
        occ_d = act == INC ? occ_q + CNT_W'(1) : act == DEC ? occ_q - CNT_W'(1) : occ_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ_q <= '0;
        else occ_q <= occ_d;
    end
`ifdef PARK_ERR_FLAG_EN
    logic err_q, err_d;
    always_comb err_d = (in_only & lot_full) | (out_only & lot_empty) | (err_q & ~err_clr);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else err_q <= err_d;
    end
    assign count_err = err_q;
`endif
endmodule
